// File: rtl/ball_kinematics.sv
// Per-ball motion engine: fixed-point position integration, periodic friction
// and cushion reflection/clamping, with overwrite ports for the collision controller.
module ball_kinematics #(
    parameter int POS_W           = 11,
    parameter int VEL_W           = 11,
    parameter int FRAC_BITS       = 6,
    parameter int FRICTION_PERIOD = 10,
    parameter int FRICTION_STEP   = 1,
    parameter int INIT_X          = 100,
    parameter int INIT_Y          = 100,
    parameter int MIN_X           = 0,
    parameter int MAX_X           = 620,
    parameter int MIN_Y           = 0,
    parameter int MAX_Y           = 460,
    parameter int BOUNCE_EN       = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    startOfFrame,
    input  logic                    velocityWriteEnable,
    input  logic signed [VEL_W-1:0] inVelocityX,
    input  logic signed [VEL_W-1:0] inVelocityY,
    input  logic                    positionWriteEnable,
    input  logic signed [POS_W-1:0] inPosX,
    input  logic signed [POS_W-1:0] inPosY,
    output logic signed [POS_W-1:0] topLeftPosX,
    output logic signed [POS_W-1:0] topLeftPosY,
    output logic signed [VEL_W-1:0] outVelocityX,
    output logic signed [VEL_W-1:0] outVelocityY,
    output logic                    ballStopped,
    output logic [3:0]              wallHit
);

    localparam int ACC_W = POS_W + FRAC_BITS + 1;
    // Two spare bits so pos + vel can never wrap before the bound compare.
    localparam int EXT_W = ACC_W + 2;
    localparam int CNT_W = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;

    localparam logic signed [EXT_W-1:0] MIN_X_ACC = EXT_W'(MIN_X * (1 << FRAC_BITS));
    localparam logic signed [EXT_W-1:0] MAX_X_ACC = EXT_W'(MAX_X * (1 << FRAC_BITS));
    localparam logic signed [EXT_W-1:0] MIN_Y_ACC = EXT_W'(MIN_Y * (1 << FRAC_BITS));
    localparam logic signed [EXT_W-1:0] MAX_Y_ACC = EXT_W'(MAX_Y * (1 << FRAC_BITS));
    localparam logic signed [ACC_W-1:0] INIT_X_ACC = ACC_W'(INIT_X * (1 << FRAC_BITS));
    localparam logic signed [ACC_W-1:0] INIT_Y_ACC = ACC_W'(INIT_Y * (1 << FRAC_BITS));

    localparam logic signed [VEL_W:0]   STEP_EXT = (VEL_W+1)'(FRICTION_STEP);
    localparam logic signed [VEL_W-1:0] VEL_MIN  = {1'b1, {(VEL_W-1){1'b0}}};
    localparam logic signed [VEL_W-1:0] VEL_MAX  = {1'b0, {(VEL_W-1){1'b1}}};
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(FRICTION_PERIOD - 1);

    logic signed [ACC_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic signed [VEL_W-1:0] vel_x_q, vel_x_d, vel_y_q, vel_y_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [3:0]              wall_hit_q, wall_hit_d;

    logic signed [ACC_W-1:0] step_pos_x_s, step_pos_y_s;
    logic signed [VEL_W-1:0] step_vel_x_s, step_vel_y_s;
    logic                    hit_lo_x_s, hit_hi_x_s, hit_lo_y_s, hit_hi_y_s;
    logic                    fric_now_s;

    // Shrinks magnitude by FRICTION_STEP, stopping at zero without changing sign.
    function automatic logic signed [VEL_W-1:0] friction_f(input logic signed [VEL_W-1:0] v);
        logic signed [VEL_W:0] w;
        logic signed [VEL_W:0] r;
        w = {v[VEL_W-1], v};
        if (w > STEP_EXT) begin
            r = w - STEP_EXT;
        end else if (w < -STEP_EXT) begin
            r = w + STEP_EXT;
        end else begin
            r = '0;
        end
        return r[VEL_W-1:0];
    endfunction

    function automatic logic signed [VEL_W-1:0] neg_sat_f(input logic signed [VEL_W-1:0] v);
        if (v == VEL_MIN) begin
            return VEL_MAX;
        end else begin
            return -v;
        end
    endfunction

    function automatic void axis_step_f(
        input  logic signed [ACC_W-1:0] pos,
        input  logic signed [VEL_W-1:0] vel,
        input  logic                    do_fric,
        input  logic signed [EXT_W-1:0] lo_acc,
        input  logic signed [EXT_W-1:0] hi_acc,
        output logic signed [ACC_W-1:0] new_pos,
        output logic signed [VEL_W-1:0] new_vel,
        output logic                    hit_lo,
        output logic                    hit_hi
    );
        logic signed [EXT_W-1:0] nxt;
        logic signed [VEL_W-1:0] v_f;
        logic signed [VEL_W-1:0] v_wall;
        nxt = EXT_W'(pos) + EXT_W'(vel);
        if (do_fric) begin
            v_f = friction_f(vel);
        end else begin
            v_f = vel;
        end
        if (BOUNCE_EN != 0) begin
            v_wall = neg_sat_f(v_f);
        end else begin
            v_wall = '0;
        end
        hit_lo = 1'b0;
        hit_hi = 1'b0;
        if (nxt < lo_acc) begin
            new_pos = lo_acc[ACC_W-1:0];
            new_vel = v_wall;
            hit_lo  = 1'b1;
        end else if (nxt > hi_acc) begin
            new_pos = hi_acc[ACC_W-1:0];
            new_vel = v_wall;
            hit_hi  = 1'b1;
        end else begin
            new_pos = nxt[ACC_W-1:0];
            new_vel = v_f;
        end
    endfunction

    // Candidate frame-step results for both axes.
    always_comb begin
        fric_now_s = (cnt_q == CNT_LAST);
        axis_step_f(pos_x_q, vel_x_q, fric_now_s, MIN_X_ACC, MAX_X_ACC,
                    step_pos_x_s, step_vel_x_s, hit_lo_x_s, hit_hi_x_s);
        axis_step_f(pos_y_q, vel_y_q, fric_now_s, MIN_Y_ACC, MAX_Y_ACC,
                    step_pos_y_s, step_vel_y_s, hit_lo_y_s, hit_hi_y_s);
    end

    // Next-state selection: writes override and suppress the frame step.
    always_comb begin
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        vel_x_d    = vel_x_q;
        vel_y_d    = vel_y_q;
        cnt_d      = cnt_q;
        wall_hit_d = 4'b0000;
        if (velocityWriteEnable || positionWriteEnable) begin
            if (velocityWriteEnable) begin
                vel_x_d = inVelocityX;
                vel_y_d = inVelocityY;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q;
            end
            if (positionWriteEnable) begin
                pos_x_d = {inPosX[POS_W-1], inPosX, {FRAC_BITS{1'b0}}};
                pos_y_d = {inPosY[POS_W-1], inPosY, {FRAC_BITS{1'b0}}};
            end else begin
                pos_x_d = pos_x_q;
            end
        end else if (startOfFrame) begin
            pos_x_d    = step_pos_x_s;
            pos_y_d    = step_pos_y_s;
            vel_x_d    = step_vel_x_s;
            vel_y_d    = step_vel_y_s;
            wall_hit_d = {hit_hi_y_s, hit_lo_y_s, hit_hi_x_s, hit_lo_x_s};
            if (fric_now_s) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            wall_hit_d = 4'b0000;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_x_q    <= INIT_X_ACC;
            pos_y_q    <= INIT_Y_ACC;
            vel_x_q    <= '0;
            vel_y_q    <= '0;
            cnt_q      <= '0;
            wall_hit_q <= 4'b0000;
        end else begin
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            vel_x_q    <= vel_x_d;
            vel_y_q    <= vel_y_d;
            cnt_q      <= cnt_d;
            wall_hit_q <= wall_hit_d;
        end
    end

    assign topLeftPosX  = pos_x_q[FRAC_BITS +: POS_W];
    assign topLeftPosY  = pos_y_q[FRAC_BITS +: POS_W];
    assign outVelocityX = vel_x_q;
    assign outVelocityY = vel_y_q;
    assign ballStopped  = (vel_x_q == '0) && (vel_y_q == '0);
    assign wallHit      = wall_hit_q;

endmodule

// File: doc/ball_kinematics.md
# ball_kinematics

Parametrised per-ball motion engine for the billiard table. Each frame it integrates a fixed-point position from a signed velocity and applies periodic friction. It also reflects the ball off the configured table cushions. The collision controller can overwrite velocity and position, for example to respawn a ball after it is pocketed. One instance sits per ball, between the collision controller and the ball drawing/VGA object path.

## Interface
- POS_W, 11, signed pixel-position width (ports).
- VEL_W, 11, signed velocity width; unit = 1/2^FRAC_BITS pixel per frame.
- FRAC_BITS, 6, fractional bits of the internal position accumulator.
- FRICTION_PERIOD, 10, frames between friction steps (>=1).
- FRICTION_STEP, 1, velocity magnitude removed per friction step, per axis.
- INIT_X / INIT_Y, 100 / 100, reset top-left position, pixels.
- MIN_X / MAX_X, 0 / 620, legal top-left X range, pixels, inclusive.
- MIN_Y / MAX_Y, 0 / 460, legal top-left Y range, pixels, inclusive.
- BOUNCE_EN, 1, 1 = reflect at bounds; 0 = clamp at the bound and zero that velocity axis.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle frame strobe.
- velocityWriteEnable  in  1  load inVelocityX/Y.
- inVelocityX, inVelocityY  in  VEL_W signed  new velocity.
- positionWriteEnable  in  1  load inPosX/Y.
- inPosX, inPosY  in  POS_W signed  new top-left position, integer pixels.
- topLeftPosX, topLeftPosY  out  POS_W signed  accumulator >>> FRAC_BITS (arithmetic, floor).
- outVelocityX, outVelocityY  out  VEL_W signed  current velocity.
- ballStopped  out  1  high when both velocity axes == 0.
- wallHit  out  4  registered one-cycle pulse; bits {bottom, top, right, left}.

## Operation
- State: posX/posY accumulators, POS_W+FRAC_BITS+1 bits signed; velX/velY; frictionCnt 0..FRICTION_PERIOD-1; wallHit register.
- Priority per cycle: reset > writes > frame step.
- Velocity write: velX/Y <= inputs; frictionCnt <= 0.
- Position write: posX/Y <= in<<FRAC_BITS.
- Both writes may occur in the same cycle; both take effect.
- If any write is asserted together with startOfFrame, the frame step is skipped entirely: no position update, counter unchanged, wallHit = 0.
- Frame step, per axis, when no write is asserted:
  - nxt = pos + sext(vel), using the old velocity.
  - Friction applies when frictionCnt == FRICTION_PERIOD-1; the counter then wraps to 0, otherwise it increments.
  - Friction: |v'| = max(|v| - FRICTION_STEP, 0), sign kept. It never crosses zero.
- Bounds, per axis:
  - If nxt < MIN<<FRAC_BITS: pos <= MIN<<FRAC_BITS and the low wallHit bit for that axis is set.
  - If nxt > MAX<<FRAC_BITS: pos <= MAX<<FRAC_BITS and the high wallHit bit for that axis is set.
  - BOUNCE_EN=1: vel <= -v', with -(−2^(VEL_W-1)) saturating to 2^(VEL_W-1)-1.
  - BOUNCE_EN=0: vel <= 0.
  - Otherwise pos <= nxt and vel <= v'.
- wallHit is 0 on every cycle without a frame step.
- X and Y are independent. A corner hit sets two bits.
- A position write outside the bounds is accepted as-is. It is corrected at the next frame step.

## Timing
- All state updates on posedge clk. Outputs are combinational from registers, so the new value is visible the cycle after the strobe or write.
- Reset values: topLeftPos = INIT_X/INIT_Y, outVelocity = 0, ballStopped = 1, wallHit = 0, frictionCnt = 0.
- Reset asserted mid-motion restores these values on the next edge and discards any pending strobe or write.
- Latency: strobe or write at cycle N; outputs updated at cycle N+1. wallHit is high for exactly cycle N+1.
- startOfFrame held high on consecutive cycles is treated as consecutive frames. This is not legal system use, but the behaviour is defined.

## Test plan
- Reset, defaults -> topLeftPos = (100,100), vel = (0,0), ballStopped = 1, wallHit = 0.
- Velocity write (64,-64), then 3 frames -> pos = (103,97), vel = (64,-64). At frame 10 friction applies -> vel = (63,-63), pos = (110,90). ballStopped = 0 throughout.
- Position write (619,10), velocity write (128,0), 1 frame:
  - nxt X = 621 > 620 -> posX = 620, velX = -128, wallHit = 4'b0010 for one cycle.
  - Repeat with BOUNCE_EN=0 -> velX = 0.
- Velocity write (-1,1), then 10 frames -> vel = (0,0) after the 10th strobe, no sign flip, ballStopped = 1. A further 20 frames leave the velocity at 0.
- velocityWriteEnable = 1 with startOfFrame = 1 and velocity (64,0) -> position unchanged, vel = new value, frictionCnt = 0.
- Negative saturation: VEL_W = 11, posX = MIN, velX = -1024, frame -> velX = 1023, wallHit[0] = 1.
- Reset asserted two cycles after a frame strobe during motion -> all outputs back to reset values next edge.
